clk_int_div_multi: RTL and testbench



---
 rtl/clk_int_div_multi.sv | 126 ++++++++++++
 tb/tb_clk_int_div_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_int_div_multi.sv
// clk_int_div_multi: NUM_CH runtime-programmable integer clock dividers
// with boundary-aligned ratio updates, glitch-free enable and settle flag.
module clk_int_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int DONE_DELAY  = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic [NUM_CH-1:0]           en_i,
   input  logic [NUM_CH*DIV_WIDTH-1:0] div_i,
   input  logic [NUM_CH-1:0]           div_valid_i,
   output logic [NUM_CH-1:0]           div_ready_o,
   output logic [NUM_CH-1:0]           div_done_o,
   output logic [NUM_CH-1:0]           clk_trg_o,
   output logic [NUM_CH-1:0]           clk_o
);

   localparam int DW = $clog2(DONE_DELAY + 1);

   typedef logic [DIV_WIDTH-1:0] div_t;
   typedef logic [DW-1:0]        dcnt_t;
   typedef enum logic {IDLE, RUN} state_t;

   localparam div_t  DEF  = div_t'(DEFAULT_DIV);
   localparam div_t  TWO  = div_t'(2);
   localparam div_t  ONE  = div_t'(1);
   localparam dcnt_t DMAX = dcnt_t'(DONE_DELAY);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t state_q, state_d;
      div_t   cnt_q, cnt_d;
      div_t   rat_q, rat_d;
      div_t   shd_q, shd_d;
      logic   pend_q, pend_d;
      logic   clk_q, clk_d;
      dcnt_t  done_q, done_d;
      div_t   raw, req;
      logic   acc, last;

      assign raw  = div_i[c*DIV_WIDTH +: DIV_WIDTH];
      assign req  = (raw < TWO) ? TWO : raw;
      assign acc  = div_valid_i[c] & ~pend_q;
      assign last = (state_q == RUN) && (cnt_q == rat_q - ONE);

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rat_q   <= DEF;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            done_q  <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rat_q   <= rat_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            done_q  <= done_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rat_d   = rat_q;
         shd_d   = shd_q;
         pend_d  = pend_q;
         clk_d   = clk_q;
         done_d  = done_q;
         unique case (state_q)
            IDLE: begin
               if (acc) begin
                  rat_d  = req;
                  done_d = '0;
               end
               if (en_i[c]) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  clk_d   = 1'b1;
               end
            end
            RUN: begin
               if (last) begin
                  cnt_d = '0;
                  // a same-cycle request wins; shadow is empty then
                  if (acc) begin
                     rat_d  = req;
                     done_d = '0;
                  end else if (pend_q) begin
                     rat_d  = shd_q;
                     pend_d = 1'b0;
                     done_d = '0;
                  end else if (done_q != DMAX) begin
                     done_d = done_q + dcnt_t'(1);
                  end
                  if (!en_i[c]) begin
                     state_d = IDLE;
                     clk_d   = 1'b0;
                  end else begin
                     clk_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
                  clk_d = cnt_d < (rat_q >> 1);
                  if (acc) begin
                     shd_d  = req;
                     pend_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      assign clk_o[c]       = clk_q;
      assign clk_trg_o[c]   = last;
      assign div_ready_o[c] = ~pend_q;
      assign div_done_o[c]  = (done_q == DMAX);
   end

endmodule

// File: tb/tb_clk_int_div_multi.sv
// tb_clk_int_div_multi: scoreboard bench for clk_int_div_multi; a
// cycle model pushes expected outputs, the monitor pops and compares.
module tb_clk_int_div_multi;

   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int DD  = 3;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    en    = '0;
   logic [NCH-1:0]    vld   = '0;
   logic [NCH*DW-1:0] div   = '0;
   logic [NCH-1:0]    rdy, done, trg, clko;

   clk_int_div_multi #(
      .NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_DIV(2), .DONE_DELAY(DD)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .div_i(div),
      .div_valid_i(vld), .div_ready_o(rdy), .div_done_o(done),
      .clk_trg_o(trg), .clk_o(clko)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] ck;
      logic [NCH-1:0] tg;
      logic [NCH-1:0] rd;
      logic [NCH-1:0] dn;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int m_run[NCH], m_pos[NCH], m_r[NCH];
   int m_pend[NCH], m_pv[NCH], m_done[NCH];
   int hi_cnt = 0;
   int lo_cnt = 0;
   bit count_on = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h",
                  tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_pos[c] = 0; m_r[c] = 2;
         m_pend[c] = 0; m_pv[c] = 0; m_done[c] = 0;
      end
   endtask

   // advance the model over the coming edge and queue what the DUT must show
   task automatic model_edge();
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         int req;
         bit acc;
         req = int'(div[c*DW +: DW]);
         if (req < 2) req = 2;
         acc = vld[c] && (m_pv[c] == 0);
         if (m_run[c] == 0) begin
            if (acc) begin m_r[c] = req; m_done[c] = 0; end
            if (en[c]) begin m_run[c] = 1; m_pos[c] = 0; end
         end else if (m_pos[c] == m_r[c] - 1) begin
            if (acc) begin
               m_r[c] = req; m_done[c] = 0;
            end else if (m_pv[c] != 0) begin
               m_r[c] = m_pend[c]; m_pv[c] = 0; m_done[c] = 0;
            end else if (m_done[c] < DD) begin
               m_done[c]++;
            end
            m_pos[c] = 0;
            if (!en[c]) m_run[c] = 0;
         end else begin
            m_pos[c]++;
            if (acc) begin m_pend[c] = req; m_pv[c] = 1; end
         end
         e.ck[c] = (m_run[c] != 0) && (m_pos[c] < m_r[c] / 2);
         e.tg[c] = (m_run[c] != 0) && (m_pos[c] == m_r[c] - 1);
         e.rd[c] = (m_pv[c] == 0);
         e.dn[c] = (m_done[c] == DD);
      end
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("clk_o", clko, e.ck);
      chk("clk_trg_o", trg, e.tg);
      chk("div_ready_o", rdy, e.rd);
      chk("div_done_o", done, e.dn);
      if (count_on) begin
         if (clko[3]) hi_cnt++;
         else lo_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic set_div(input int c, input int v);
      div[c*DW +: DW] = DW'(v);
   endtask

   task automatic wait_pos(input int c, input int p);
      int n;
      n = 0;
      while (m_run[c] == 0 || m_pos[c] != p) begin
         if (n == 200) begin
            chk("wait_pos", 32'(m_pos[c]), 32'(p));
            break;
         end
         step();
         n++;
      end
   endtask

   function automatic bit any_last();
      bit r;
      r = 0;
      for (int c = 0; c < NCH; c++)
         if (m_run[c] == 0 || m_pos[c] == m_r[c] - 1) r = 1;
      return r;
   endfunction

   initial begin
      model_reset();
      #2;
      chk("rst_clk", clko, 0);
      chk("rst_trg", trg, 0);
      chk("rst_rdy", rdy, 4'hf);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      set_div(1, 4); set_div(2, 6);
      vld = 4'b0110; step(); vld = '0;
      chk("idle_rdy", rdy, 4'hf);
      en = 4'b0111;
      repeat (14) step();
      chk("ch0_done", done[0], 1);

      wait_pos(1, 0);
      set_div(1, 5); vld[1] = 1'b1; step(); vld[1] = 1'b0;
      chk("ch1_rdy_low", rdy[1], 0);
      repeat (3) step();
      chk("ch1_rdy_back", rdy[1], 1);
      chk("ch1_done_clr", done[1], 0);
      repeat (14) step();
      chk("ch1_done_14", done[1], 0);
      step();
      chk("ch1_done_15", done[1], 1);

      wait_pos(2, 1);
      en[2] = 1'b0;
      repeat (10) step();
      chk("ch2_held", clko[2], 0);
      en[2] = 1'b1; step();
      chk("ch2_rise", clko[2], 1);

      set_div(0, 0); vld[0] = 1'b1; step(); vld[0] = 1'b0;
      repeat (6) step();
      set_div(0, 1); vld[0] = 1'b1; step(); vld[0] = 1'b0;
      repeat (6) step();

      wait_pos(1, 4);
      set_div(1, 3); vld[1] = 1'b1; step(); vld[1] = 1'b0;
      chk("byp_rdy", rdy[1], 1);
      wait_pos(1, 0);
      set_div(1, 7); vld[1] = 1'b1; step();
      set_div(1, 9); step(); vld[1] = 1'b0;
      repeat (24) step();

      set_div(3, 65535); set_div(0, 4);
      vld = 4'b1001; step(); vld = '0;
      count_on = 1; en[3] = 1'b1;
      repeat (65535) step();
      count_on = 0;
      chk("big_hi", 32'(hi_cnt), 32767);
      chk("big_lo", 32'(lo_cnt), 32768);
      step();

      for (int n = 0; n < 100 && any_last(); n++) step();
      set_div(0, 8); set_div(1, 9); set_div(2, 10); set_div(3, 11);
      vld = 4'hf; step(); vld = '0;
      chk("pend_rdy", rdy, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_clk", clko, 0);
      chk("arst_rdy", rdy, 4'hf);
      chk("arst_done", done, 0);
      chk("arst_trg", trg, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
